// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD MM:SS stopwatch.
package stopwatch_pkg;

    // Controller states; encoding is fixed so downstream debug taps can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int             BCD_W        = 4;
    localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    // Increment one BCD digit that rolls over after max.
    // Returns {carry, next_digit}. Any value at or above max rolls to zero,
    // so a corrupted digit recovers to a legal BCD value on its next increment.
    function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] digit,
                                               input logic [BCD_W-1:0] max);
        logic [BCD_W:0] result;
        if (digit >= max) begin
            result = {1'b1, {BCD_W{1'b0}}};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for a slow asynchronous level, followed by a
// history flop that turns each synchronised rising edge into a one-cycle pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 remembers the previous synchronised level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD MM:SS stopwatch with start/pause toggle and level-sensitive clear.
// The divided clock from the divider is sampled as data; only clk clocks flops.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped at 00:00, ticks ignored, waiting for start
//   RUN   | counting; every PRESCALE ticks advances one second
//   PAUSE | digits and prescaler frozen, ticks ignored
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE  = 2,
    parameter int MIN_LIMIT = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start_stop,
    input  logic             clear,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             wrap
);

    localparam int             PRESC_W  = 8;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(PRESCALE - 1);
    localparam logic [BCD_W-1:0]   ML_TENS  = BCD_W'(MIN_LIMIT / 10);
    localparam logic [BCD_W-1:0]   ML_ONES  = BCD_W'(MIN_LIMIT % 10);

    state_t               state;
    state_t               next_state;
    logic                 tick_ev;
    logic                 start_stop_d;
    logic                 ss_ev;
    logic                 count_en;
    logic [PRESC_W-1:0]   presc;
    logic                 at_limit;
    logic [BCD_W:0]       so_inc;
    logic [BCD_W:0]       st_inc;
    logic [BCD_W:0]       mo_inc;
    logic                 carry_st;
    logic                 carry_mo;
    logic                 carry_mt;
    logic [BCD_W-1:0]     nxt_so;
    logic [BCD_W-1:0]     nxt_st;
    logic [BCD_W-1:0]     nxt_mo;
    logic [BCD_W-1:0]     nxt_mt;

    sync_edge_det u_tick_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (tick_in),
        .pulse (tick_ev)
    );

    // start_stop is already in the clk domain, so a single history flop suffices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_stop_d <= 1'b0;
        end else begin
            start_stop_d <= start_stop;
        end
    end

    assign ss_ev = start_stop & ~start_stop_d;

    // A toggle on the same edge as a tick wins, so that tick is discarded;
    // clear overrides both inside the datapath register.
    assign count_en = tick_ev & (state == RUN) & ~ss_ev;

    // State register; running is registered alongside so it tracks state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
        end
    end

    // Next-state decode: clear beats the start/stop toggle.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else if (ss_ev) begin
            unique case (state)
                IDLE:    next_state = RUN;
                RUN:     next_state = PAUSE;
                PAUSE:   next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    // One-second advance of the MM:SS value with BCD carries and wrap at MIN_LIMIT:59.
    always_comb begin
        so_inc   = bcd_inc(sec_ones, BCD_MAX);
        st_inc   = bcd_inc(sec_tens, SEC_TENS_MAX);
        mo_inc   = bcd_inc(min_ones, BCD_MAX);
        carry_st = so_inc[BCD_W];
        carry_mo = carry_st & st_inc[BCD_W];
        carry_mt = carry_mo & mo_inc[BCD_W];
        at_limit = (min_tens == ML_TENS) && (min_ones == ML_ONES) &&
                   (sec_tens == SEC_TENS_MAX) && (sec_ones == BCD_MAX);

        nxt_so = so_inc[BCD_W-1:0];
        nxt_st = carry_st ? st_inc[BCD_W-1:0] : sec_tens;
        nxt_mo = carry_mo ? mo_inc[BCD_W-1:0] : min_ones;
        nxt_mt = min_tens;
        if (carry_mt) begin
            nxt_mt = (min_tens >= BCD_MAX) ? '0 : min_tens + 4'd1;
        end

        if (at_limit) begin
            nxt_so = '0;
            nxt_st = '0;
            nxt_mo = '0;
            nxt_mt = '0;
        end
    end

    // Prescaler, digits and wrap pulse; wrap defaults low every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                presc    <= '0;
                sec_ones <= '0;
                sec_tens <= '0;
                min_ones <= '0;
                min_tens <= '0;
            end else if (count_en) begin
                if (presc == PRESC_TC) begin
                    presc    <= '0;
                    sec_ones <= nxt_so;
                    sec_tens <= nxt_st;
                    min_ones <= nxt_mo;
                    min_tens <= nxt_mt;
                    wrap     <= at_limit;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch (PRESCALE=2, MIN_LIMIT=1).
module tb_bcd_stopwatch;

    localparam int PRESCALE = 2;
    localparam int MIN_LIMIT = 1;
    localparam int PERIOD_S = (MIN_LIMIT + 1) * 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;

    always #5 clk = ~clk;

    bcd_stopwatch #(
        .PRESCALE  (PRESCALE),
        .MIN_LIMIT (MIN_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .wrap       (wrap)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: elapsed seconds, tick prescaler, state (0 idle, 1 run, 2 pause).
    int m_secs = 0;
    int m_presc = 0;
    int m_state = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    int wrap_cycles = 0;

    always @(negedge clk) begin
        if (wrap === 1'b1) wrap_cycles++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pack_exp(input int secs, input bit run);
        logic [31:0] r;
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        r = '0;
        r[16]    = run;
        r[15:12] = 4'(m / 10);
        r[11:8]  = 4'(m % 10);
        r[7:4]   = 4'(s / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    function automatic logic [31:0] observed();
        return {15'd0, running, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic sb_push(input string tag);
        exp_q.push_back(pack_exp(m_secs, m_state == 1));
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop();
        logic [31:0] e;
        string       t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, observed(), e);
        end
    endtask

    task automatic model_tick();
        if (m_state == 1) begin
            m_presc++;
            if (m_presc == PRESCALE) begin
                m_presc = 0;
                m_secs  = (m_secs + 1) % PERIOD_S;
            end
        end
    endtask

    task automatic model_toggle();
        m_state = (m_state == 1) ? 2 : 1;
    endtask

    // One clean tick_in pulse: 3 cycles high, 3 low.
    task automatic do_tick(input string tag);
        @(negedge clk) tick_in = 1'b1;
        model_tick();
        sb_push(tag);
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        sb_pop();
    endtask

    task automatic press(input int hold, input string tag);
        @(negedge clk) start_stop = 1'b1;
        model_toggle();
        sb_push(tag);
        repeat (hold) @(negedge clk);
        start_stop = 1'b0;
        @(negedge clk);
        sb_pop();
    endtask

    // Tick whose tick_ev lands on the same edge as a start_stop rise (and optionally clear).
    task automatic coincident(input bit with_clear, input string tag);
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_stop = 1'b1;
        clear      = with_clear;
        if (with_clear) begin
            m_state = 0;
            m_secs  = 0;
            m_presc = 0;
        end else begin
            model_toggle();
        end
        sb_push(tag);
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        sb_pop();
    endtask

    task automatic run_to(input int secs, input string tag);
        for (int k = 0; k < 2000 && (m_secs != secs || m_presc != 0); k++) begin
            do_tick(tag);
        end
    endtask

    int wrap_base;

    initial begin
        // Reset held with tick_in high.
        repeat (3) @(negedge clk);
        check_val("rst_digits", observed(), 32'd0);
        check_val("rst_wrap", {31'd0, wrap}, 32'd0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) do_tick("idle_tick");

        // Start with a held button: one event only.
        press(5, "start_held");
        do_tick("first_tick");
        // Second tick: increment lands exactly at E2.
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("pre_e2", observed(), pack_exp(m_secs, 1'b1));
        model_tick();
        @(negedge clk);
        check_val("at_e2", observed(), pack_exp(m_secs, 1'b1));
        @(negedge clk) tick_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) do_tick("to_0003");

        // Seconds carries into minutes, then wrap at MIN_LIMIT:59.
        run_to(59, "to_0059");
        do_tick("carry_a");
        do_tick("carry_0100");
        run_to(119, "to_0159");
        wrap_base = wrap_cycles;
        do_tick("wrap_a");
        do_tick("wrap_0000");
        check_val("wrap_width", 32'(wrap_cycles - wrap_base), 32'd1);

        // Pause holds, resume continues.
        run_to(5, "to_0005");
        press(1, "pause");
        for (int i = 0; i < 8; i++) do_tick("paused");
        press(1, "resume");
        do_tick("resume_a");
        do_tick("resume_0006");

        // RUN->PAUSE coincident with a tick: tick dropped.
        do_tick("half_sec");
        coincident(1'b0, "pause_drop");
        press(1, "resume2");
        do_tick("after_drop_0007");
        // PAUSE->RUN coincident with a tick: tick dropped.
        press(1, "pause2");
        coincident(1'b0, "resume_drop");
        do_tick("resume_drop_a");
        do_tick("resume_drop_0008");

        // Clear together with start_stop and tick at 00:12.
        run_to(12, "to_0012");
        do_tick("presc_one");
        coincident(1'b1, "clear_all");
        do_tick("idle_after_clear");
        press(1, "start_after_clear");
        do_tick("presc_zero_a");
        do_tick("presc_zero_0001");

        // Asynchronous reset between clock edges at 00:12.
        run_to(12, "to_0012b");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("async_rst", {wrap, observed()}, 32'd0);
        m_state = 0;
        m_secs  = 0;
        m_presc = 0;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        press(1, "start_after_rst");
        do_tick("post_rst_a");
        do_tick("post_rst_0001");

        check_val("wrap_total", 32'(wrap_cycles), 32'd1);
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
